// File: rtl/rs422_pkg.sv
// Shared RS422 UART definitions: FSM encoding, oversampling defaults,
// and baud constants common to the receiver and the planned transmitter.
package rs422_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_TICK_DEF   = 7;

    localparam int SYS_CLK_HZ = 59_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int TICK_HZ    = BAUD_RATE * OVERSAMPLE_DEF;

endpackage

// File: rtl/rs422_sync_edge.sv
// Two-flop synchroniser with selectable reset value and an optional
// one-cycle rising-edge pulse taken from a third delay flop.
module rs422_sync_edge #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            dly  <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign q    = sync;
    assign rise = EDGE_EN ? (sync & ~dly) : 1'b0;

endmodule

// File: rtl/rs422_uart_rx.sv
// 16x oversampling RS422 UART receiver; clk1_8m is sampled as data
// and turned into a one-cycle tick that paces the whole FSM.
module rs422_uart_rx
    import rs422_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID_TICK   = MID_TICK_DEF
) (
    input  logic       clk59m,
    input  logic       rst,
    input  logic       clk1_8m,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID       = 4'(MID_TICK);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       PODD      = 1'(PARITY_ODD);

    logic rxd_s;
    logic tick;
    logic rxd_rise_unused;
    logic ck_s_unused;

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [3:0]           tick_cnt;
    logic [3:0]           tick_nxt;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 perr_q;
    logic                 perr_nxt;
    logic                 stop_smp;

    // Line idles high, so the rxd chain resets to 1 to avoid a false start.
    rs422_sync_edge #(
        .RST_VAL (1'b1),
        .EDGE_EN (1'b0)
    ) u_sync_rxd (
        .clk  (clk59m),
        .rst  (rst),
        .d    (rxd),
        .q    (rxd_s),
        .rise (rxd_rise_unused)
    );

    rs422_sync_edge #(
        .RST_VAL (1'b0),
        .EDGE_EN (1'b1)
    ) u_sync_tick (
        .clk  (clk59m),
        .rst  (rst),
        .d    (clk1_8m),
        .q    (ck_s_unused),
        .rise (tick)
    );

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        perr_nxt  = perr_q;
        stop_smp  = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == MID) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt  = '0;
                        bit_nxt   = bit_cnt + 1'b1;
                        shreg_nxt = {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt  = '0;
                        perr_nxt  = (^shreg) ^ rxd_s ^ PODD;
                        state_nxt = STOP;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt  = '0;
                        stop_smp  = 1'b1;
                        state_nxt = rxd_s ? IDLE : BREAK;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk59m or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            perr_q   <= perr_nxt;
            rx_valid <= stop_smp;
            if (stop_smp) begin
                rx_data    <= 8'(shreg);
                frame_err  <= ~rxd_s;
                parity_err <= perr_q;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_rs422_uart_rx.sv
// Self-checking bench: two receivers (8N1 and 8O1) fed by a jittery
// scaled divider model, checked against a frame-level expectation queue.
module tb_rs422_uart_rx;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk59m = 1'b0;
    logic       rst = 1'b0;
    logic       clk1_8m = 1'b0;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic [7:0] rx_data_a;
    logic       rx_valid_a;
    logic       frame_err_a;
    logic       parity_err_a;
    logic       rx_busy_a;
    logic [7:0] rx_data_b;
    logic       rx_valid_b;
    logic       frame_err_b;
    logic       parity_err_b;
    logic       rx_busy_b;

    int checks = 0;
    int errors = 0;

    exp_t       q [2][$];
    logic [7:0] last_d [2];
    logic       last_f [2];
    logic       last_p [2];
    logic       pv [2];
    int         nval [2];
    logic [7:0] got_d [2];
    logic       got_f [2];
    logic       got_p [2];

    rs422_uart_rx #(
        .DATA_BITS  (8),
        .PARITY_EN  (0),
        .PARITY_ODD (0)
    ) dut_a (
        .clk59m     (clk59m),
        .rst        (rst),
        .clk1_8m    (clk1_8m),
        .rxd        (rxd_a),
        .rx_data    (rx_data_a),
        .rx_valid   (rx_valid_a),
        .frame_err  (frame_err_a),
        .parity_err (parity_err_a),
        .rx_busy    (rx_busy_a)
    );

    rs422_uart_rx #(
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (1)
    ) dut_b (
        .clk59m     (clk59m),
        .rst        (rst),
        .clk1_8m    (clk1_8m),
        .rxd        (rxd_b),
        .rx_data    (rx_data_b),
        .rx_valid   (rx_valid_b),
        .frame_err  (frame_err_b),
        .parity_err (parity_err_b),
        .rx_busy    (rx_busy_b)
    );

    always #5 clk59m = ~clk59m;

    // Divider model, time-scaled: half periods of 3..5 system clocks.
    initial begin
        int cnt;
        int len;
        cnt = 0;
        len = 4;
        forever begin
            @(negedge clk59m);
            if (cnt >= len - 1) begin
                clk1_8m = ~clk1_8m;
                cnt = 0;
                len = $urandom_range(3, 5);
            end else begin
                cnt++;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string nm,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int s, input logic v, input logic [7:0] d,
                       input logic f, input logic p);
        exp_t e;
        if (v) begin
            nval[s]++;
            chk(pv[s] == 1'b0, "valid_gap", 1, 0);
            chk(q[s].size() != 0, "unexpected_valid", q[s].size(), 1);
            if (q[s].size() != 0) begin
                e = q[s].pop_front();
                chk(d == e.data, "data", d, e.data);
                chk(f == e.ferr, "frame_err", f, e.ferr);
                chk(p == e.perr, "parity_err", p, e.perr);
                last_d[s] = e.data;
                last_f[s] = e.ferr;
                last_p[s] = e.perr;
            end
            got_d[s] = d;
            got_f[s] = f;
            got_p[s] = p;
        end else begin
            chk(d == last_d[s], "hold_data", d, last_d[s]);
            chk(f == last_f[s], "hold_ferr", f, last_f[s]);
            chk(p == last_p[s], "hold_perr", p, last_p[s]);
        end
        pv[s] = v;
    endtask

    always @(negedge clk59m) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                last_d[s] = '0;
                last_f[s] = 1'b0;
                last_p[s] = 1'b0;
                pv[s] = 1'b0;
            end
        end else begin
            mon(0, rx_valid_a, rx_data_a, frame_err_a, parity_err_a);
            mon(1, rx_valid_b, rx_data_b, frame_err_b, parity_err_b);
        end
    end

    task automatic line(input int s, input logic v);
        if (s == 1) rxd_b = v;
        else rxd_a = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk1_8m);
    endtask

    // Line B carries odd parity; an error is flagged when the total
    // count of ones over data plus parity bit comes out even.
    task automatic send_frame(input int s, input logic [7:0] d,
                              input logic pbit, input logic stopv,
                              input int idle_bits);
        exp_t e;
        int ones;
        line(s, 1'b0);
        hold(OS);
        for (int i = 0; i < 8; i++) begin
            line(s, d[i]);
            hold(OS);
        end
        ones = $countones(d);
        if (s == 1) begin
            line(s, pbit);
            hold(OS);
            ones += int'(pbit);
        end
        e.data = d;
        e.ferr = ~stopv;
        e.perr = (s == 1) && (ones % 2 == 0);
        q[s].push_back(e);
        line(s, stopv);
        hold(OS * (1 + idle_bits));
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && i < 4000) begin
            @(negedge clk59m);
            i++;
        end
        chk(q[0].size() == 0 && q[1].size() == 0, "drain_timeout",
            q[0].size() + q[1].size(), 0);
    endtask

    task automatic chk_reset_outs();
        chk(rx_data_a == 8'h00, "rst_data", rx_data_a, 0);
        chk(rx_valid_a == 1'b0, "rst_valid", rx_valid_a, 0);
        chk(frame_err_a == 1'b0, "rst_ferr", frame_err_a, 0);
        chk(parity_err_a == 1'b0, "rst_perr", parity_err_a, 0);
        chk(rx_busy_a == 1'b0, "rst_busy", rx_busy_a, 0);
        chk(rx_busy_b == 1'b0, "rst_busy_b", rx_busy_b, 0);
    endtask

    initial begin
        logic [7:0] rd;
        for (int s = 0; s < 2; s++) begin
            nval[s] = 0;
            got_d[s] = '0;
            got_f[s] = 1'b0;
            got_p[s] = 1'b0;
        end
        repeat (5) @(negedge clk59m);
        chk_reset_outs();
        rst = 1'b1;
        hold(4 * OS);

        send_frame(0, 8'h55, 1'b0, 1'b1, 2);
        wait_drain();
        chk(nval[0] == 1, "f55_count", nval[0], 1);
        chk(got_d[0] == 8'h55, "f55_data", got_d[0], 8'h55);
        chk(got_f[0] == 1'b0, "f55_ferr", got_f[0], 0);
        chk(rx_busy_a == 1'b0, "f55_busy", rx_busy_a, 0);

        send_frame(0, 8'hA3, 1'b0, 1'b1, 0);
        send_frame(0, 8'h0F, 1'b0, 1'b1, 2);
        wait_drain();
        chk(nval[0] == 3, "b2b_count", nval[0], 3);
        chk(got_d[0] == 8'h0F, "b2b_data", got_d[0], 8'h0F);

        line(0, 1'b0);
        hold(2);
        chk(rx_busy_a == 1'b1, "glitch_busy_hi", rx_busy_a, 1);
        hold(2);
        line(0, 1'b1);
        hold(2 * OS);
        chk(rx_busy_a == 1'b0, "glitch_busy_lo", rx_busy_a, 0);
        chk(nval[0] == 3, "glitch_count", nval[0], 3);

        send_frame(0, 8'h81, 1'b0, 1'b0, 0);
        hold(40 * OS);
        chk(nval[0] == 4, "brk_count", nval[0], 4);
        chk(got_d[0] == 8'h81, "brk_data", got_d[0], 8'h81);
        chk(got_f[0] == 1'b1, "brk_ferr", got_f[0], 1);
        chk(rx_busy_a == 1'b1, "brk_busy", rx_busy_a, 1);
        line(0, 1'b1);
        hold(2 * OS);
        chk(rx_busy_a == 1'b0, "brk_idle", rx_busy_a, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 2);
        wait_drain();
        chk(got_d[0] == 8'h3C, "post_brk_data", got_d[0], 8'h3C);
        chk(got_f[0] == 1'b0, "post_brk_ferr", got_f[0], 0);
        chk(nval[0] == 5, "post_brk_count", nval[0], 5);

        send_frame(1, 8'h07, 1'b0, 1'b1, 2);
        wait_drain();
        chk(got_p[1] == 1'b0, "par_ok", got_p[1], 0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 2);
        wait_drain();
        chk(got_p[1] == 1'b1, "par_err", got_p[1], 1);
        chk(nval[1] == 2, "par_count", nval[1], 2);

        line(0, 1'b0);
        hold(OS);
        for (int i = 0; i < 4; i++) begin
            line(0, 1'b1);
            hold(OS);
        end
        chk(rx_busy_a == 1'b1, "mid_busy", rx_busy_a, 1);
        hold(OS / 2);
        rst = 1'b0;
        repeat (3) @(negedge clk59m);
        chk_reset_outs();
        hold(2);
        rst = 1'b1;
        hold(2 * OS);
        chk(rx_busy_a == 1'b0, "post_rst_busy", rx_busy_a, 0);
        send_frame(0, 8'h12, 1'b0, 1'b1, 2);
        wait_drain();
        chk(nval[0] == 6, "post_rst_count", nval[0], 6);
        chk(got_d[0] == 8'h12, "post_rst_data", got_d[0], 8'h12);
        chk(got_f[0] == 1'b0, "post_rst_ferr", got_f[0], 0);

        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom_range(0, 255));
            send_frame(0, rd, 1'b0, 1'b1, $urandom_range(0, 2));
            rd = 8'($urandom_range(0, 255));
            send_frame(1, rd, 1'($urandom_range(0, 1)), 1'b1,
                       $urandom_range(0, 2));
        end
        wait_drain();
        chk(nval[0] == 12, "rand_count_a", nval[0], 12);
        chk(nval[1] == 8, "rand_count_b", nval[1], 8);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
